// File: rtl/spu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// spu_pipe_pkg
//   Shared constants, types and helpers for the front-end pipeline
//   registers of the SPU core.
//
//   Contents:
//     PIPE_LANES        default number of instruction slots per fetch group
//     PIPE_INSTR_W      instruction width in bits
//     PIPE_PC_W         program counter width in bits
//     PIPE_INSTR_BYTES  byte stride between consecutive lanes
//     PIPE_NOP_INSTR    encoding driven on empty / killed lanes
//     MAX_LANES         widest lane vector the helper functions accept
//     lane_cnt_t        lane count type sized for PIPE_LANES (0..PIPE_LANES)
//     popcount()        number of set bits in a lane-valid vector
//     first_gap()       index of the first deasserted valid bit
// ---------------------------------------------------------------------------
package spu_pipe_pkg;

  localparam int PIPE_LANES       = 2;
  localparam int PIPE_INSTR_W     = 32;
  localparam int PIPE_PC_W        = 32;
  localparam int PIPE_INSTR_BYTES = 4;
  localparam logic [PIPE_INSTR_W-1:0] PIPE_NOP_INSTR = '0;

  // Helpers take a fixed-width vector so that any lane count up to this
  // bound can share them; callers zero-extend their valid vectors.
  localparam int MAX_LANES = 32;

  typedef logic [$clog2(PIPE_LANES+1)-1:0] lane_cnt_t;

  function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  // Returns the lowest lane index in [0, n) whose valid bit is clear, or n
  // when the low n lanes are all valid. Lanes at or above the returned index
  // are treated as invalid, which makes any valid vector contiguous.
  function automatic int first_gap(input logic [MAX_LANES-1:0] v, input int n);
    int g;
    g = n;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (i < n && !v[i]) g = i;
    end
    return g;
  endfunction

endpackage

// File: rtl/if_id_lane_shift.sv
// ---------------------------------------------------------------------------
// if_id_lane_shift
//   Combinational lane shifter for the IF/ID register. Moves every
//   {instruction, valid} pair down by shamt lanes; lanes vacated at the top
//   are filled with NOP_INSTR and valid 0.
//
//   Ports:
//     instr_in   in   LANES*INSTR_W  lane 0 in the LSBs
//     valid_in   in   LANES          per-lane valid
//     shamt      in   CNT_W          lanes to drop from the bottom
//     instr_out  out  LANES*INSTR_W  shifted instructions
//     valid_out  out  LANES          shifted valids
// ---------------------------------------------------------------------------
module if_id_lane_shift #(
  parameter int LANES   = 2,
  parameter int INSTR_W = 32,
  parameter int CNT_W   = 2,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic [LANES*INSTR_W-1:0] instr_in,
  input  logic [LANES-1:0]         valid_in,
  input  logic [CNT_W-1:0]         shamt,
  output logic [LANES*INSTR_W-1:0] instr_out,
  output logic [LANES-1:0]         valid_out
);

  always_comb begin
    instr_out = {LANES{NOP_INSTR}};
    valid_out = '0;
    for (int i = 0; i < LANES; i++) begin
      int src;
      src = i + int'(shamt);
      if (src < LANES) begin
        instr_out[i*INSTR_W +: INSTR_W] = instr_in[src*INSTR_W +: INSTR_W];
        valid_out[i]                    = valid_in[src];
      end
    end
  end

endmodule

// File: rtl/if_id_lane.sv
// ---------------------------------------------------------------------------
// if_id_lane_reg
//   Multi-lane IF/ID pipeline register. Holds up to LANES fetched
//   instructions plus the PC of lane 0, with contiguous per-lane valids.
//   Supports stall (hold), flush (kill) and partial issue, where ID takes
//   fewer lanes than are held and the remainder shifts down and re-presents
//   with an advanced PC. Fetch is back-pressured through ready_if.
//
//   Ports:
//     clk        in   1              clock, all state on posedge
//     reset      in   1              synchronous, active-low reset
//     instr_if   in   LANES*INSTR_W  fetched group, lane 0 in the LSBs
//     valid_if   in   LANES          per-lane valid from fetch
//     pc_if      in   PC_W           PC of fetch-group lane 0
//     ready_if   out  1              a new group is accepted this cycle
//     flush      in   1              kill held and incoming lanes
//     stall      in   1              hold all state
//     issue_cnt  in   CNT_W          lanes consumed by ID this cycle
//     instr_id   out  LANES*INSTR_W  held instructions
//     valid_id   out  LANES          held valids (contiguous from lane 0)
//     pc_id      out  PC_W           PC of instr_id lane 0
//     err_issue  out  1              sticky: issue_cnt exceeded held count
// ---------------------------------------------------------------------------
module if_id_lane_reg
  import spu_pipe_pkg::*;
#(
  parameter int LANES       = PIPE_LANES,
  parameter int INSTR_W     = PIPE_INSTR_W,
  parameter int PC_W        = PIPE_PC_W,
  parameter int INSTR_BYTES = PIPE_INSTR_BYTES,
  parameter logic [INSTR_W-1:0] NOP_INSTR = PIPE_NOP_INSTR
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [LANES*INSTR_W-1:0]       instr_if,
  input  logic [LANES-1:0]               valid_if,
  input  logic [PC_W-1:0]                pc_if,
  output logic                           ready_if,
  input  logic                           flush,
  input  logic                           stall,
  input  logic [$clog2(LANES+1)-1:0]     issue_cnt,
  output logic [LANES*INSTR_W-1:0]       instr_id,
  output logic [LANES-1:0]               valid_id,
  output logic [PC_W-1:0]                pc_id,
  output logic                           err_issue
);

  localparam int CNT_W = $clog2(LANES+1);

  logic [LANES*INSTR_W-1:0] instr_p1;
  logic [LANES-1:0]         vld_p1;
  logic [PC_W-1:0]          pc_p1;
  logic                     err_p1;

  logic [CNT_W-1:0]         held;
  logic [CNT_W-1:0]         issue_eff;
  logic                     over_issue;
  logic                     load;
  int                       gap;
  logic [LANES*INSTR_W-1:0] instr_in_n;
  logic [LANES-1:0]         vld_in_n;
  logic [LANES*INSTR_W-1:0] instr_shift;
  logic [LANES-1:0]         vld_shift;
  logic [PC_W-1:0]          pc_step;

  // Stage p0: fetch-side normalisation and issue accounting
  always_comb begin
    gap        = first_gap(MAX_LANES'(valid_if), LANES);
    instr_in_n = {LANES{NOP_INSTR}};
    vld_in_n   = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < gap) begin
        vld_in_n[i]                      = 1'b1;
        instr_in_n[i*INSTR_W +: INSTR_W] = instr_if[i*INSTR_W +: INSTR_W];
      end
    end
  end

  // The held group is always contiguous, so its popcount is also the index
  // of the first empty lane.
  assign held       = CNT_W'(popcount(MAX_LANES'(vld_p1)));
  assign ready_if   = ~stall & ~flush & (issue_cnt >= held);
  assign over_issue = ~stall & ~flush & (issue_cnt > held);
  assign issue_eff  = over_issue ? held : issue_cnt;
  assign load       = valid_if[0] & ready_if;
  assign pc_step    = PC_W'(issue_eff) * PC_W'(INSTR_BYTES);

  if_id_lane_shift #(
    .LANES     (LANES),
    .INSTR_W   (INSTR_W),
    .CNT_W     (CNT_W),
    .NOP_INSTR (NOP_INSTR)
  ) u_shift (
    .instr_in  (instr_p1),
    .valid_in  (vld_p1),
    .shamt     (issue_eff),
    .instr_out (instr_shift),
    .valid_out (vld_shift)
  );

  // Stage p1: IF/ID register
  always_ff @(posedge clk) begin
    if (!reset) begin
      instr_p1 <= {LANES{NOP_INSTR}};
      vld_p1   <= '0;
      pc_p1    <= '0;
      err_p1   <= 1'b0;
    end else begin
      // Over-issue is only judged on cycles where ID is really consuming.
      if (over_issue) err_p1 <= 1'b1;

      if (flush) begin
        instr_p1 <= {LANES{NOP_INSTR}};
        vld_p1   <= '0;
      end else if (!stall) begin
        if (load) begin
          instr_p1 <= instr_in_n;
          vld_p1   <= vld_in_n;
          pc_p1    <= pc_if;
        end else if (issue_cnt >= held) begin
          // Whole group consumed (or already empty) and nothing new arrived.
          instr_p1 <= {LANES{NOP_INSTR}};
          vld_p1   <= '0;
        end else if (issue_cnt != '0) begin
          // Partial issue: survivors move to lane 0 and PC follows them.
          instr_p1 <= instr_shift;
          vld_p1   <= vld_shift;
          pc_p1    <= pc_p1 + pc_step;
        end
      end
    end
  end

  assign instr_id  = instr_p1;
  assign valid_id  = vld_p1;
  assign pc_id     = pc_p1;
  assign err_issue = err_p1;

endmodule

// File: tb/tb_if_id_lane_reg.sv
// ---------------------------------------------------------------------------
// tb_if_id_lane_reg
//   Self-checking bench for if_id_lane_reg (LANES=2). The reference model
//   keeps the held group as a queue of instructions plus a PC and a sticky
//   error bit; output lanes are the queue padded with NOPs.
// ---------------------------------------------------------------------------
module tb_if_id_lane_reg;
  import spu_pipe_pkg::*;

  localparam int LANES = 2;
  localparam int IW    = 32;
  localparam int PW    = 32;
  localparam logic [IW-1:0] NOP = '0;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  flush = 1'b0;
  logic                  stall = 1'b0;
  lane_cnt_t             issue_cnt = '0;
  logic [LANES-1:0]      valid_if = '0;
  logic [LANES*IW-1:0]   instr_if = '0;
  logic [PW-1:0]         pc_if = '0;
  logic                  ready_if;
  logic [LANES*IW-1:0]   instr_id;
  logic [LANES-1:0]      valid_id;
  logic [PW-1:0]         pc_id;
  logic                  err_issue;

  always #5 clk = ~clk;

  if_id_lane_reg #(
    .LANES       (LANES),
    .INSTR_W     (IW),
    .PC_W        (PW),
    .INSTR_BYTES (4),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .instr_if  (instr_if),
    .valid_if  (valid_if),
    .pc_if     (pc_if),
    .ready_if  (ready_if),
    .flush     (flush),
    .stall     (stall),
    .issue_cnt (issue_cnt),
    .instr_id  (instr_id),
    .valid_id  (valid_id),
    .pc_id     (pc_id),
    .err_issue (err_issue)
  );

  // Reference model state
  logic [IW-1:0] mq[$];
  logic [PW-1:0] mpc = '0;
  logic          merr = 1'b0;
  logic          rdy_exp;
  logic          rdy_obs;

  int vectors    = 0;
  int miscompares = 0;

  function automatic logic [LANES*IW-1:0] exp_instr();
    logic [LANES*IW-1:0] v;
    v = {LANES{NOP}};
    for (int i = 0; i < LANES; i++)
      if (i < mq.size()) v[i*IW +: IW] = mq[i];
    return v;
  endfunction

  function automatic logic [LANES-1:0] exp_valid();
    logic [LANES-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++)
      if (i < mq.size()) v[i] = 1'b1;
    return v;
  endfunction

  // Applies one cycle of inputs (called at a negedge), captures ready_if
  // before the edge, advances the model, and returns at the next negedge.
  task automatic drive_cycle(input logic r, input logic fl, input logic st,
                             input lane_cnt_t ic, input logic [LANES-1:0] vi,
                             input logic [LANES*IW-1:0] ii, input logic [PW-1:0] pci);
    reset     = r;
    flush     = fl;
    stall     = st;
    issue_cnt = ic;
    valid_if  = vi;
    instr_if  = ii;
    pc_if     = pci;
    #1;
    rdy_obs = ready_if;
    rdy_exp = !st && !fl && (int'(ic) >= mq.size());
    @(posedge clk);
    if (!r) begin
      mq.delete();
      mpc  = '0;
      merr = 1'b0;
    end else if (fl) begin
      mq.delete();
    end else if (!st) begin
      if (int'(ic) > mq.size()) merr = 1'b1;
      if (vi[0] && rdy_exp) begin
        mq.delete();
        for (int i = 0; i < LANES; i++) begin
          if (!vi[i]) break;
          mq.push_back(ii[i*IW +: IW]);
        end
        mpc = pci;
      end else if (int'(ic) >= mq.size()) begin
        mq.delete();
      end else begin
        for (int k = 0; k < int'(ic); k++) begin
          void'(mq.pop_front());
          mpc = mpc + 32'd4;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive_cycle(1'b0, 1'b1, 1'b1, 2'd2, 2'b11, {32'h1111_1111, 32'h2222_2222}, 32'h50);
    drive_cycle(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    vectors++;
    if (instr_id !== '0 || valid_id !== 2'b00 || pc_id !== '0 || err_issue !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got instr=%h valid=%b pc=%h err=%b, want 0 00 0 0",
               instr_id, valid_id, pc_id, err_issue);
    end
    vectors++;
    if (rdy_obs !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b, want 1", rdy_obs);
    end
  endtask

  task automatic test_load_b2b();
    logic [PW-1:0] pc;
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd2, 2'b11, {32'hBBBB_0002, 32'hAAAA_0001}, 32'h100);
    vectors++;
    if (instr_id !== {32'hBBBB_0002, 32'hAAAA_0001} || valid_id !== 2'b11 || pc_id !== 32'h100) begin
      miscompares++;
      $display("FAIL load_first: got instr=%h valid=%b pc=%h, want bbbb0002aaaa0001 11 100",
               instr_id, valid_id, pc_id);
    end
    pc = 32'h100;
    for (int g = 0; g < 4; g++) begin
      logic [LANES*IW-1:0] grp;
      grp = {$urandom, $urandom};
      pc  = pc + 32'd8;
      drive_cycle(1'b1, 1'b0, 1'b0, 2'd2, 2'b11, grp, pc);
      vectors++;
      if (rdy_obs !== 1'b1 || instr_id !== grp || valid_id !== 2'b11 || pc_id !== pc) begin
        miscompares++;
        $display("FAIL back_to_back[%0d]: got rdy=%b instr=%h valid=%b pc=%h, want 1 %h 11 %h",
                 g, rdy_obs, instr_id, valid_id, pc_id, grp, pc);
      end
    end
  endtask

  task automatic test_partial_issue();
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'b11, {32'hBBBB_0002, 32'hAAAA_0001}, 32'h100);
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd1, 2'b00, '0, '0);
    vectors++;
    if (rdy_obs !== 1'b0) begin
      miscompares++;
      $display("FAIL partial_ready: got %b, want 0", rdy_obs);
    end
    vectors++;
    if (instr_id !== {NOP, 32'hBBBB_0002} || valid_id !== 2'b01 || pc_id !== 32'h104) begin
      miscompares++;
      $display("FAIL partial_shift: got instr=%h valid=%b pc=%h, want 00000000bbbb0002 01 104",
               instr_id, valid_id, pc_id);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd1, 2'b11, {32'hDDDD_0004, 32'hCCCC_0003}, 32'h300);
    vectors++;
    if (rdy_obs !== 1'b1 || instr_id !== {32'hDDDD_0004, 32'hCCCC_0003} ||
        valid_id !== 2'b11 || pc_id !== 32'h300 || err_issue !== 1'b0) begin
      miscompares++;
      $display("FAIL partial_reload: got rdy=%b instr=%h valid=%b pc=%h err=%b, want 1 ddddcccc 11 300 0",
               rdy_obs, instr_id, valid_id, pc_id, err_issue);
    end
  endtask

  task automatic test_stall_flush();
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'b11, {32'hBBBB_0002, 32'hAAAA_0001}, 32'h100);
    for (int c = 0; c < 3; c++) begin
      drive_cycle(1'b1, 1'b0, 1'b1, 2'd2, 2'b11, {32'hDDDD_0004, 32'hCCCC_0003}, 32'h300);
      vectors++;
      if (rdy_obs !== 1'b0 || instr_id !== {32'hBBBB_0002, 32'hAAAA_0001} ||
          valid_id !== 2'b11 || pc_id !== 32'h100 || err_issue !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got rdy=%b instr=%h valid=%b pc=%h err=%b, want 0 bbbbaaaa 11 100 0",
                 c, rdy_obs, instr_id, valid_id, pc_id, err_issue);
      end
    end
    drive_cycle(1'b1, 1'b1, 1'b1, 2'd2, 2'b11, {32'hDDDD_0004, 32'hCCCC_0003}, 32'h300);
    vectors++;
    if (rdy_obs !== 1'b0 || instr_id !== '0 || valid_id !== 2'b00 || pc_id !== 32'h100) begin
      miscompares++;
      $display("FAIL stall_flush: got rdy=%b instr=%h valid=%b pc=%h, want 0 0 00 100",
               rdy_obs, instr_id, valid_id, pc_id);
    end
  endtask

  task automatic test_normalise_wrap();
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'b10, {32'hBBBB_0002, 32'hAAAA_0001}, 32'h200);
    vectors++;
    if (instr_id !== '0 || valid_id !== 2'b00 || pc_id !== 32'h0) begin
      miscompares++;
      $display("FAIL norm_lane0_invalid: got instr=%h valid=%b pc=%h, want 0 00 0",
               instr_id, valid_id, pc_id);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'b11, {32'hBBBB_0002, 32'hAAAA_0001}, 32'hFFFF_FFFC);
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd1, 2'b00, '0, '0);
    vectors++;
    if (pc_id !== 32'h0 || valid_id !== 2'b01 || instr_id !== {NOP, 32'hBBBB_0002}) begin
      miscompares++;
      $display("FAIL pc_wrap: got instr=%h valid=%b pc=%h, want 00000000bbbb0002 01 0",
               instr_id, valid_id, pc_id);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd1, 2'b01, {32'hEEEE_0005, 32'hCCCC_0003}, 32'h400);
    vectors++;
    if (instr_id !== {NOP, 32'hCCCC_0003} || valid_id !== 2'b01 || pc_id !== 32'h400) begin
      miscompares++;
      $display("FAIL norm_upper_dropped: got instr=%h valid=%b pc=%h, want 00000000cccc0003 01 400",
               instr_id, valid_id, pc_id);
    end
  endtask

  task automatic test_over_issue();
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'b01, {32'hBBBB_0002, 32'hAAAA_0001}, 32'h40);
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd2, 2'b00, '0, '0);
    vectors++;
    if (valid_id !== 2'b00 || err_issue !== 1'b1 || pc_id !== 32'h40) begin
      miscompares++;
      $display("FAIL over_issue: got valid=%b err=%b pc=%h, want 00 1 40", valid_id, err_issue, pc_id);
    end
    drive_cycle(1'b1, 1'b1, 1'b0, 2'd0, 2'b00, '0, '0);
    vectors++;
    if (err_issue !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky_flush: got %b, want 1", err_issue);
    end
    drive_cycle(1'b1, 1'b0, 1'b0, 2'd0, 2'b11, {32'hBBBB_0002, 32'hAAAA_0001}, 32'h80);
    drive_cycle(1'b0, 1'b0, 1'b0, 2'd1, 2'b00, '0, '0);
    vectors++;
    if (instr_id !== '0 || valid_id !== 2'b00 || pc_id !== '0 || err_issue !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_issue: got instr=%h valid=%b pc=%h err=%b, want 0 00 0 0",
               instr_id, valid_id, pc_id, err_issue);
    end
  endtask

  task automatic test_random();
    drive_cycle(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    for (int n = 0; n < 400; n++) begin
      logic r, fl, st;
      lane_cnt_t ic;
      r  = ($urandom_range(0, 49) != 0);
      fl = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 4) == 0);
      ic = ($urandom_range(0, 7) == 0) ? 2'd3 : lane_cnt_t'($urandom_range(0, 2));
      drive_cycle(r, fl, st, ic, LANES'($urandom_range(0, 3)), {$urandom, $urandom}, $urandom);
      vectors++;
      if (rdy_obs !== rdy_exp || instr_id !== exp_instr() || valid_id !== exp_valid() ||
          pc_id !== mpc || err_issue !== merr) begin
        miscompares++;
        $display("FAIL random[%0d]: got rdy=%b instr=%h valid=%b pc=%h err=%b, want %b %h %b %h %b",
                 n, rdy_obs, instr_id, valid_id, pc_id, err_issue,
                 rdy_exp, exp_instr(), exp_valid(), mpc, merr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_b2b();
    test_partial_issue();
    test_stall_flush();
    test_normalise_wrap();
    test_over_issue();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_lane_reg.md
Name: if_id_lane_reg

Overview:
Parametrised successor to the dual-issue IF/ID pipeline register. It holds up to LANES fetched instructions plus the fetch-group PC, with per-lane valid bits. It supports stall (hold), flush (kill), and partial issue: ID consumes fewer lanes than are held, and the remainder shifts down and re-presents. It sits between the fetch unit and the ID/dual-issue check, and back-pressures fetch through ready_if.

Parameters:
LANES, 2, instruction slots per fetch group (≥1)
INSTR_W, 32, instruction width in bits
PC_W, 32, program counter width
INSTR_BYTES, 4, byte stride between consecutive lanes
NOP_INSTR, 0, encoding driven on invalid or flushed lanes

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-low reset; asserted when reset==0 at posedge clk
instr_if  in  LANES*INSTR_W  fetched instructions; lane 0 in the LSBs
valid_if  in  LANES  per-lane valid from fetch
pc_if  in  PC_W  PC of lane 0 of the fetch group
ready_if  out  1  register accepts a new group this cycle (combinational)
flush  in  1  kill all held and incoming lanes
stall  in  1  hold all state; no issue, no load
issue_cnt  in  $clog2(LANES+1)  lanes ID consumes this cycle (lane 0 upward)
instr_id  out  LANES*INSTR_W  held instructions to ID
valid_id  out  LANES  per-lane valid to ID
pc_id  out  PC_W  PC of instr_id lane 0
err_issue  out  1  sticky: issue_cnt exceeded held count while not stalled

Behaviour:
- Reset (reset==0 at posedge):
  - instr_id = all NOP_INSTR, valid_id = 0, pc_id = 0, err_issue = 0.
  - Reset overrides flush, stall and load.
- Valid normalisation: valid_if is treated as contiguous from lane 0. Lanes at or above the first deasserted bit count as invalid and are stored as NOP_INSTR with valid 0.
- held = popcount(valid_id). valid_id is always contiguous from lane 0.
- ready_if = ~stall & ~flush & (issue_cnt ≥ held). True when empty, or when the held group is fully consumed this cycle.
- Priority at posedge, highest first: reset > flush > stall > load/issue.
- flush:
  - valid_id <= 0, instr_id <= NOP_INSTR on all lanes, pc_id holds.
  - Any incoming group is discarded (ready_if is 0).
  - err_issue is unaffected.
- stall:
  - All outputs hold, issue_cnt is ignored, and err_issue does not update.
  - A flush in the same cycle still flushes.
- Load (valid_if[0] & ready_if): instr_id <= normalised instr_if, valid_id <= normalised valid_if, pc_id <= pc_if. Latency from fetch to ID is 1 cycle.
- Partial issue (~stall & ~flush & 0 < issue_cnt < held):
  - Lanes shift down by issue_cnt; vacated top lanes become NOP_INSTR, valid 0.
  - pc_id <= pc_id + issue_cnt*INSTR_BYTES, modulo 2^PC_W (wrap-around allowed).
  - No load.
- Full consume without a new group (issue_cnt ≥ held, no valid_if[0]): valid_id <= 0, instr_id <= NOP_INSTR, pc_id holds.
- issue_cnt == 0 and not ready: hold.
- Over-issue (issue_cnt > held, ~stall, ~flush):
  - Treated as issue_cnt = held.
  - err_issue <= 1 and stays set until reset.
- No combinational path from instr_if to instr_id; ready_if depends only on stall, flush, issue_cnt and state.

Decomposition:
- Shared package spu_pipe_pkg:
  - INSTR_W, PC_W, INSTR_BYTES, NOP_INSTR constants
  - lane_cnt_t typedef ($clog2(LANES+1) bits)
  - popcount/contiguous-normalise functions
- Sub-module if_id_lane_shift: combinational shifter, {instr, valid} × LANES shifted down by N with NOP fill. Instantiated once.

Test Plan:
1. LANES=2. Reset low 2 cycles, then high, idle → valid_id=00, instr_id=0, pc_id=0, ready_if=1, err_issue=0.
2. Load instr_if={B,A}, valid_if=11, pc_if=0x100, issue_cnt=2 each cycle → next cycle instr_id={B,A}, valid_id=11, pc_id=0x100. Back-to-back groups each advance in 1 cycle with ready_if=1 throughout.
3. Hold {B,A} at pc_id=0x100, issue_cnt=1 → ready_if=0. Next cycle instr_id={0,B}, valid_id=01, pc_id=0x104. Then issue_cnt=1 with a new group valid → ready_if=1 and the group loads.
4. Hold {B,A}, stall=1 for 3 cycles with issue_cnt=2 → outputs unchanged, ready_if=0. stall=1 with flush=1 → valid_id=00, instr_id=0, pc_id unchanged.
5. valid_if=10 with pc_if=0x200 → both lanes stored invalid, nothing loads, valid_id=00. pc_id=0xFFFFFFFC with valid_id=11, issue_cnt=1 → pc_id=0x00000000.
6. Hold one valid lane, issue_cnt=2 → valid_id=00 next cycle and err_issue=1, sticky through a flush. reset=0 asserted mid-partial-issue → all outputs return to reset values next posedge.
